// File: rtl/stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stage_pkg
// Purpose  : Room encodings, key codes and zone bounds for stage_control.
// Revision : 1.0 - initial release
// ============================================================================
package stage_pkg;

    localparam logic [2:0] STAGE_0 = 3'd0;
    localparam logic [2:0] STAGE_1 = 3'd1;
    localparam logic [2:0] STAGE_2 = 3'd2;
    localparam logic [2:0] STAGE_3 = 3'd3;
    localparam logic [2:0] STAGE_4 = 3'd4;
    localparam logic [2:0] STAGE_5 = 3'd5;
    localparam logic [2:0] STAGE_6 = 3'd6;

    localparam logic [8:0] F5 = 9'h003;
    localparam logic [8:0] F6 = 9'h00B;

    // Only the bounds that actually constrain a zone exist; open sides are omitted.
    localparam logic [9:0] ZONE_0_1_L_MIN = 10'd312;
    localparam logic [9:0] ZONE_0_1_L_MAX = 10'd401;
    localparam logic [9:0] ZONE_0_1_U_MAX = 10'd11;

    localparam logic [9:0] ZONE_0_6_L_MIN = 10'd201;
    localparam logic [9:0] ZONE_0_6_L_MAX = 10'd301;
    localparam logic [9:0] ZONE_0_6_U_MIN = 10'd430;

    localparam logic [9:0] ZONE_1_2_L_MAX = 10'd81;
    localparam logic [9:0] ZONE_1_2_U_MIN = 10'd311;
    localparam logic [9:0] ZONE_1_2_U_MAX = 10'd381;

    localparam logic [9:0] ZONE_1_3_L_MIN = 10'd111;
    localparam logic [9:0] ZONE_1_3_L_MAX = 10'd191;
    localparam logic [9:0] ZONE_1_3_U_MIN = 10'd81;
    localparam logic [9:0] ZONE_1_3_U_MAX = 10'd121;

    localparam logic [9:0] ZONE_1_4_L_MIN = 10'd111;
    localparam logic [9:0] ZONE_1_4_L_MAX = 10'd191;
    localparam logic [9:0] ZONE_1_4_U_MIN = 10'd231;
    localparam logic [9:0] ZONE_1_4_U_MAX = 10'd271;

    localparam logic [9:0] ZONE_1_0_L_MIN = 10'd211;
    localparam logic [9:0] ZONE_1_0_L_MAX = 10'd261;
    localparam logic [9:0] ZONE_1_0_U_MIN = 10'd401;

    localparam logic [9:0] ZONE_2_1_L_MIN = 10'd381;
    localparam logic [9:0] ZONE_2_1_L_MAX = 10'd391;
    localparam logic [9:0] ZONE_2_1_U_MIN = 10'd306;
    localparam logic [9:0] ZONE_2_1_U_MAX = 10'd346;

    localparam logic [9:0] ZONE_2_5_L_MIN = 10'd221;
    localparam logic [9:0] ZONE_2_5_L_MAX = 10'd261;
    localparam logic [9:0] ZONE_2_5_U_MIN = 10'd211;
    localparam logic [9:0] ZONE_2_5_U_MAX = 10'd251;

    localparam logic [9:0] ZONE_5_2_L_MIN = 10'd461;
    localparam logic [9:0] ZONE_5_2_L_MAX = 10'd481;
    localparam logic [9:0] ZONE_5_2_U_MIN = 10'd281;
    localparam logic [9:0] ZONE_5_2_U_MAX = 10'd346;

    localparam logic [9:0] ZONE_6_0_L_MIN = 10'd201;
    localparam logic [9:0] ZONE_6_0_L_MAX = 10'd301;
    localparam logic [9:0] ZONE_6_0_U_MIN = 10'd421;
    localparam logic [9:0] ZONE_6_0_U_MAX = 10'd441;

    function automatic logic in_span(logic [9:0] v, logic [9:0] lo, logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/second_tick.sv
`default_nettype none
// ============================================================================
// Module   : second_tick
// Purpose  : Free-running 0..CLK_HZ-1 counter emitting a one-cycle wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
module second_tick #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              c_cw   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(CLK_HZ - 1);

    logic [c_cw-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
        end
    end

    assign tick = en && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/stage_control.sv
`default_nettype none
// ============================================================================
// Module   : stage_control
// Purpose  : Room selection from player position and keys, level countdown,
//            and sticky win/loss freeze.
// Revision : 1.0 - initial release
// ============================================================================
module stage_control #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TIME_LIMIT_S = 180,
    parameter int HOLD_CYCLES  = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  people_left,
    input  logic [9:0]  people_up,
    input  logic [12:0] key_down,
    input  logic [8:0]  last_change,
    input  logic        been_ready,
    input  logic        apple,
    output logic [2:0]  stage_state,
    output logic        stage_changed,
    output logic        fail,
    output logic        success,
    output logic [7:0]  time_left
);
    import stage_pkg::*;

    localparam int               c_cdw   = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [c_cdw-1:0] c_hold  = c_cdw'(HOLD_CYCLES);
    localparam logic [7:0]       c_limit = 8'(TIME_LIMIT_S);

    logic [c_cdw-1:0] r_cooldown;
    logic             w_frozen;
    logic             w_tick;
    logic             w_f5;
    logic             w_f6;
    logic             w_hit;
    logic [2:0]       w_next;

    assign w_frozen = fail | success;
    assign w_f5     = been_ready && (last_change == F5) && key_down[F5[3:0]];
    assign w_f6     = been_ready && (last_change == F6) && key_down[F6[3:0]];

    second_tick #(.CLK_HZ(CLK_HZ)) u_second_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (!w_frozen),
        .tick (w_tick)
    );

    // Only the current room's exits are examined; earlier entries take priority.
    always_comb begin
        w_hit  = 1'b0;
        w_next = stage_state;
        case (stage_state)
            STAGE_0: begin
                if (in_span(people_left, ZONE_0_1_L_MIN, ZONE_0_1_L_MAX) && people_up <= ZONE_0_1_U_MAX) begin
                    w_hit = 1'b1; w_next = STAGE_1;
                end else if (in_span(people_left, ZONE_0_6_L_MIN, ZONE_0_6_L_MAX) && people_up >= ZONE_0_6_U_MIN) begin
                    w_hit = 1'b1; w_next = STAGE_6;
                end
            end
            STAGE_1: begin
                if (people_left <= ZONE_1_2_L_MAX && in_span(people_up, ZONE_1_2_U_MIN, ZONE_1_2_U_MAX)) begin
                    w_hit = 1'b1; w_next = STAGE_2;
                end else if (w_f5 && in_span(people_left, ZONE_1_3_L_MIN, ZONE_1_3_L_MAX)
                             && in_span(people_up, ZONE_1_3_U_MIN, ZONE_1_3_U_MAX)) begin
                    w_hit = 1'b1; w_next = STAGE_3;
                end else if (w_f5 && in_span(people_left, ZONE_1_4_L_MIN, ZONE_1_4_L_MAX)
                             && in_span(people_up, ZONE_1_4_U_MIN, ZONE_1_4_U_MAX)) begin
                    w_hit = 1'b1; w_next = STAGE_4;
                end else if (in_span(people_left, ZONE_1_0_L_MIN, ZONE_1_0_L_MAX) && people_up >= ZONE_1_0_U_MIN) begin
                    w_hit = 1'b1; w_next = STAGE_0;
                end
            end
            STAGE_2: begin
                if (in_span(people_left, ZONE_2_1_L_MIN, ZONE_2_1_L_MAX) && in_span(people_up, ZONE_2_1_U_MIN, ZONE_2_1_U_MAX)) begin
                    w_hit = 1'b1; w_next = STAGE_1;
                end else if (w_f5 && in_span(people_left, ZONE_2_5_L_MIN, ZONE_2_5_L_MAX)
                             && in_span(people_up, ZONE_2_5_U_MIN, ZONE_2_5_U_MAX)) begin
                    w_hit = 1'b1; w_next = STAGE_5;
                end
            end
            STAGE_3, STAGE_4: begin
                if (w_f6) begin
                    w_hit = 1'b1; w_next = STAGE_1;
                end
            end
            STAGE_5: begin
                if (in_span(people_left, ZONE_5_2_L_MIN, ZONE_5_2_L_MAX) && in_span(people_up, ZONE_5_2_U_MIN, ZONE_5_2_U_MAX)) begin
                    w_hit = 1'b1; w_next = STAGE_2;
                end
            end
            STAGE_6: begin
                if (in_span(people_left, ZONE_6_0_L_MIN, ZONE_6_0_L_MAX) && in_span(people_up, ZONE_6_0_U_MIN, ZONE_6_0_U_MAX)) begin
                    w_hit = 1'b1; w_next = STAGE_0;
                end
            end
            default: begin
                w_hit = 1'b1; w_next = STAGE_0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_state   <= STAGE_0;
            stage_changed <= 1'b0;
            fail          <= 1'b0;
            success       <= 1'b0;
            time_left     <= c_limit;
            r_cooldown    <= '0;
        end else begin
            stage_changed <= 1'b0;
            if (!w_frozen) begin
                if (r_cooldown == '0 && w_hit) begin
                    stage_state   <= w_next;
                    stage_changed <= 1'b1;
                    r_cooldown    <= c_hold;
                end else if (r_cooldown != '0) begin
                    r_cooldown <= r_cooldown - 1'b1;
                end
                if (w_tick && time_left != 8'd0) begin
                    time_left <= time_left - 8'd1;
                end
                // A win in the same cycle as a timeout takes precedence.
                if (apple && stage_state == STAGE_0) begin
                    success <= 1'b1;
                end else if (time_left == 8'd0) begin
                    fail <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_control
// Purpose  : Directed and randomized checks of stage_control against a
//            zone-table reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_control;

    localparam int CLK_HZ = 10;
    localparam int HOLD   = 4;
    localparam int TLIM   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  people_left = '0;
    logic [9:0]  people_up = 10'd500;
    logic [12:0] key_down = '0;
    logic [8:0]  last_change = '0;
    logic        been_ready = 1'b0;
    logic        apple = 1'b0;
    logic [2:0]  stage_state;
    logic        stage_changed;
    logic        fail;
    logic        success;
    logic [7:0]  time_left;

    stage_control #(.CLK_HZ(CLK_HZ), .TIME_LIMIT_S(TLIM), .HOLD_CYCLES(HOLD)) dut (
        .clk           (clk),
        .rst           (rst),
        .people_left   (people_left),
        .people_up     (people_up),
        .key_down      (key_down),
        .last_change   (last_change),
        .been_ready    (been_ready),
        .apple         (apple),
        .stage_state   (stage_state),
        .stage_changed (stage_changed),
        .fail          (fail),
        .success       (success),
        .time_left     (time_left)
    );

    always #5 clk = ~clk;

    // Exit table: source room, destination, inclusive box, required key (0 = none).
    typedef struct {
        int from; int to; int lmin; int lmax; int umin; int umax; int key;
    } zone_t;

    zone_t zones [11] = '{
        '{0, 1, 312, 401,   0,   11, 0},
        '{0, 6, 201, 301, 430, 1023, 0},
        '{1, 2,   0,  81, 311,  381, 0},
        '{1, 3, 111, 191,  81,  121, 3},
        '{1, 4, 111, 191, 231,  271, 3},
        '{1, 0, 211, 261, 401, 1023, 0},
        '{2, 1, 381, 391, 306,  346, 0},
        '{2, 5, 221, 261, 211,  251, 3},
        '{3, 1,   0, 1023,  0, 1023, 11},
        '{4, 1,   0, 1023,  0, 1023, 11},
        '{5, 2, 461, 481, 281,  346, 0}
    };
    zone_t zone_6_0 = '{6, 0, 201, 301, 421, 441, 0};

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    int m_stage, m_elapsed, m_since, m_next, m_tl, m_old;
    bit m_changed, m_fail, m_success;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_time_left();
        int t;
        t = TLIM - m_elapsed / CLK_HZ;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic bit zone_match(zone_t z, int st, int l, int u);
        if (z.from != st) return 1'b0;
        if (l < z.lmin || l > z.lmax || u < z.umin || u > z.umax) return 1'b0;
        if (z.key == 0) return 1'b1;
        return been_ready && (int'(last_change) == z.key) && key_down[z.key];
    endfunction

    function automatic int lookup(int st, int l, int u);
        for (int i = 0; i < 11; i++)
            if (zone_match(zones[i], st, l, u)) return zones[i].to;
        if (zone_match(zone_6_0, st, l, u)) return 0;
        return -1;
    endfunction

    // Reference: time is the count of unfrozen cycles; exits are allowed once
    // HOLD cycles have elapsed since the last room change.
    always @(posedge clk) begin
        if (rst) begin
            m_stage = 0; m_changed = 0; m_fail = 0; m_success = 0;
            m_elapsed = 0; m_since = HOLD;
        end else if (!(m_fail || m_success)) begin
            m_tl  = model_time_left();
            m_old = m_stage;
            m_next = (m_since >= HOLD) ? lookup(m_stage, int'(people_left), int'(people_up)) : -1;
            if (m_next >= 0) begin
                m_stage = m_next; m_changed = 1; m_since = 0;
            end else begin
                m_changed = 0;
                if (m_since < HOLD) m_since++;
            end
            if (apple && m_old == 0) m_success = 1;
            else if (m_tl == 0) m_fail = 1;
            m_elapsed++;
        end else begin
            m_changed = 0;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("stage_state", int'(stage_state), m_stage);
            chk("stage_changed", int'(stage_changed), int'(m_changed));
            chk("fail", int'(fail), int'(m_fail));
            chk("success", int'(success), int'(m_success));
            chk("time_left", int'(time_left), model_time_left());
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_pos(input int l, input int u);
        people_left = 10'(l);
        people_up   = 10'(u);
    endtask

    task automatic do_reset();
        rst = 1'b1; apple = 1'b0; been_ready = 1'b0; key_down = '0; last_change = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic randomize_inputs();
        int n, pick, cnt;
        rst = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 2) != 0) begin
            cnt = 0;
            for (int i = 0; i < 11; i++) if (zones[i].from == m_stage) cnt++;
            if (m_stage == 6) cnt = 1;
            pick = $urandom_range(0, cnt - 1);
            n = 0;
            if (m_stage == 6) begin
                set_pos(zone_6_0.lmin + $urandom_range(0, zone_6_0.lmax - zone_6_0.lmin),
                        zone_6_0.umin + $urandom_range(0, zone_6_0.umax - zone_6_0.umin));
            end else begin
                for (int i = 0; i < 11; i++) begin
                    if (zones[i].from == m_stage) begin
                        if (n == pick)
                            set_pos(zones[i].lmin + $urandom_range(0, zones[i].lmax - zones[i].lmin),
                                    zones[i].umin + $urandom_range(0, zones[i].umax - zones[i].umin));
                        n++;
                    end
                end
            end
        end else begin
            set_pos($urandom_range(0, 1023), $urandom_range(0, 1023));
        end
        been_ready = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 2))
            0:       last_change = 9'h003;
            1:       last_change = 9'h00B;
            default: last_change = 9'($urandom_range(0, 511));
        endcase
        key_down = 13'($urandom);
        apple = ($urandom_range(0, 29) == 0);
    endtask

    initial begin
        // Reset values
        set_pos(0, 500);
        do_reset();
        check_en = 1'b1;
        chk("rst_stage", int'(stage_state), 0);
        chk("rst_changed", int'(stage_changed), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_success", int'(success), 0);
        chk("rst_time_left", int'(time_left), 3);

        // Stage 0 -> 1 with one-cycle change pulse
        set_pos(350, 5);
        cyc();
        chk("s0_to_s1_stage", int'(stage_state), 1);
        chk("s0_to_s1_pulse", int'(stage_changed), 1);
        set_pos(0, 500);
        cyc();
        chk("pulse_drops", int'(stage_changed), 0);
        chk("stays_s1", int'(stage_state), 1);

        // Cooldown delays the stage 1 -> 2 exit
        do_reset();
        set_pos(350, 5);
        cyc();
        set_pos(40, 340);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("cooldown_hold_s1", int'(stage_state), 1);
        end
        cyc();
        chk("after_cooldown_s2", int'(stage_state), 2);
        chk("after_cooldown_pulse", int'(stage_changed), 1);

        // F5 into stage 3, F6 back to stage 1
        do_reset();
        set_pos(350, 5);
        cyc();
        set_pos(150, 100);
        repeat (5) cyc();
        chk("no_key_stays_s1", int'(stage_state), 1);
        been_ready = 1'b1; last_change = 9'h003; key_down = 13'h0008;
        cyc();
        chk("f5_to_s3", int'(stage_state), 3);
        been_ready = 1'b0; key_down = '0;
        repeat (5) cyc();
        chk("s3_holds", int'(stage_state), 3);
        been_ready = 1'b1; last_change = 9'h00B; key_down = 13'h0800;
        cyc();
        chk("f6_to_s1", int'(stage_state), 1);
        been_ready = 1'b0; key_down = '0;

        // Countdown to timeout in stage 2, then frozen
        do_reset();
        set_pos(350, 5);
        cyc();
        set_pos(40, 340);
        repeat (5) cyc();
        chk("timer_s2", int'(stage_state), 2);
        set_pos(0, 0);
        for (int k = 7; k <= 31; k++) begin
            cyc();
            chk("countdown", int'(time_left), (k >= 30) ? 0 : 3 - k / 10);
            chk("fail_timing", int'(fail), (k >= 31) ? 1 : 0);
        end
        set_pos(385, 320);
        repeat (3) begin
            cyc();
            chk("frozen_stage", int'(stage_state), 2);
            chk("frozen_no_pulse", int'(stage_changed), 0);
        end
        chk("frozen_fail", int'(fail), 1);

        // Win in the same cycle as timeout
        do_reset();
        set_pos(0, 200);
        repeat (30) cyc();
        chk("tl_zero", int'(time_left), 0);
        chk("not_failed_yet", int'(fail), 0);
        apple = 1'b1;
        cyc();
        chk("win_success", int'(success), 1);
        chk("win_over_fail", int'(fail), 0);
        repeat (3) cyc();
        chk("win_sticky", int'(success), 1);
        chk("win_fail_low", int'(fail), 0);

        // Reset during cooldown in stage 6
        do_reset();
        set_pos(250, 450);
        cyc();
        chk("to_s6", int'(stage_state), 6);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_stage", int'(stage_state), 0);
        chk("mid_rst_time", int'(time_left), 3);
        chk("mid_rst_fail", int'(fail), 0);
        chk("mid_rst_success", int'(success), 0);
        cyc();
        chk("post_rst_hit", int'(stage_state), 6);
        chk("post_rst_pulse", int'(stage_changed), 1);

        // Randomized phase
        repeat (4000) begin
            randomize_inputs();
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage_control.md
Name: stage_control

Overview:
- Upstream producer of `stage_state`, `fail` and `success` for the player-movement block.
- Watches the player anchor position (`people_left`, `people_up`) and keyboard events, and decides which room (stage 0..6) is shown.
- Runs the level countdown and freezes the game on win or loss.
- Registered outputs feed both the player-movement block and the VGA renderer.

Parameters:
- CLK_HZ, 100_000_000, clock frequency; used to derive the 1 s tick.
- TIME_LIMIT_S, 180, countdown length in seconds (max 255).
- HOLD_CYCLES, 2_000_000, cooldown after any stage change; all triggers are ignored while it runs.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- people_left  in  10  player x anchor, pixels
- people_up  in  10  player y anchor, pixels
- key_down  in  13  key-held vector from the keyboard decoder
- last_change  in  9  most recent key code
- been_ready  in  1  key-event valid strobe
- apple  in  1  level-held "apple collected" flag
- stage_state  out  3  current room, 0..6
- stage_changed  out  1  one-cycle pulse in the cycle `stage_state` takes a new value
- fail  out  1  sticky loss flag
- success  out  1  sticky win flag
- time_left  out  8  seconds remaining

Behaviour:
- Reset values: `stage_state`=0, `stage_changed`=0, `fail`=0, `success`=0, `time_left`=TIME_LIMIT_S, cooldown=0, tick counter=0.
- Press event for key K: `been_ready` && `key_down[last_change]` && `last_change`==K. Codes: F5=9'h003, F6=9'h00B.
- Zone tests are inclusive compares on the unregistered anchor inputs. Evaluate only the current stage's list, in the order below; the first match wins:
  - Stage 0:
    - 312<=L<=401 and U<=11 -> 1
    - 201<=L<=301 and U>=430 -> 6
  - Stage 1:
    - L<=81 and 311<=U<=381 -> 2
    - 111<=L<=191 and 81<=U<=121 and F5 press -> 3
    - 111<=L<=191 and 231<=U<=271 and F5 press -> 4
    - 211<=L<=261 and U>=401 -> 0
  - Stage 2:
    - 381<=L<=391 and 306<=U<=346 -> 1
    - 221<=L<=261 and 211<=U<=251 and F5 press -> 5
  - Stages 3 and 4: F6 press -> 1.
  - Stage 5: 461<=L<=481 and 281<=U<=346 -> 2
  - Stage 6: 201<=L<=301 and 421<=U<=441 -> 0
- Transition timing:
  - A match in cycle n updates `stage_state` at edge n+1; the position is unchanged at that point.
  - The same edge pulses `stage_changed` for exactly one cycle and loads cooldown=HOLD_CYCLES.
  - Cooldown decrements by 1 per cycle down to 0. Zones and key triggers are evaluated only when cooldown==0.
  - Encodings 7 never occur; if seen, force stage 0.
- Timer:
  - The tick counter counts 0..CLK_HZ-1 and wraps.
  - On wrap, `time_left` decrements if it is nonzero.
  - When `time_left` reaches 0, `fail` sets at the next edge.
- Win: `apple`==1 and `stage_state`==0 -> `success` sets at the next edge.
- Same-cycle conflict: if the fail and success conditions hold in the same cycle, `success` wins and `fail` stays 0.
- Freeze: once `fail` or `success` is 1, `stage_state`, the timer and the cooldown hold. No transitions occur and there are no `stage_changed` pulses until `rst`.
- `rst` mid-cooldown or mid-transition returns to the reset values at the next edge.
- Widths:
  - Tick counter is $clog2(CLK_HZ) bits.
  - Cooldown counter is $clog2(HOLD_CYCLES+1) bits.
  - All zone compares use 10-bit unsigned values; no addition is applied to the anchors.

Decomposition:
- Package `stage_pkg`:
  - stage encodings STAGE_0..STAGE_6
  - key codes F5, F6
  - all zone bound constants, named ZONE_<from>_<to>_{L_MIN,L_MAX,U_MIN,U_MAX}
- One sub-module, `second_tick`:
  - parameter CLK_HZ; ports clk, rst, en; output pulse `tick`.
  - The countdown logic consumes the pulse.

Test Plan (CLK_HZ=10, HOLD_CYCLES=4, TIME_LIMIT_S=3):
- Reset, then hold L=350, U=5 in stage 0 -> `stage_state`=1 and `stage_changed`=1 one edge later; `stage_changed`=0 on the following cycle.
- In stage 1, drive L=40, U=340 immediately after entry -> `stage_state` stays 1 for 4 cycles (cooldown), then becomes 2.
- In stage 1 at L=150, U=100: F5 press with cooldown=0 -> `stage_state`=3. Then F6 press (last_change=9'h00B, been_ready=1) -> `stage_state`=1.
- Idle in stage 2 -> `time_left` goes 3,2,1,0 every 10 cycles; `fail`=1 one edge after reaching 0. Later zone hits cause no change and no `stage_changed` pulse.
- `apple`=1 in stage 0 in the same cycle `time_left` hits 0 -> `success`=1, `fail`=0; both remain set.
- Assert `rst` during cooldown in stage 6 -> next edge: `stage_state`=0, `time_left`=3, flags 0. A stage 0 zone hit is accepted immediately afterwards.
